// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
//   arb_state_t    : arbiter FSM states
//   MEM_LAT_DEF    : default memory read latency (cycles from m_en to m_rdata)
//   STARVE_LIM_DEF : default number of consecutive data grants allowed while a fetch waits
//   LAT_W/STARVE_W : counter widths sized for the legal parameter ranges (1..7, 1..15)
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } arb_state_t;

    localparam int unsigned MEM_LAT_DEF    = 1;
    localparam int unsigned STARVE_LIM_DEF = 4;
    localparam int unsigned LAT_W          = 3;
    localparam int unsigned STARVE_W       = 4;

endpackage

// File: rtl/arb_pick.sv
// Combinational grant selector for the memory arbiter.
// Data requests win, unless the fetch port has already lost STARVE_LIM grants in a row.
//   i_req, d_req : pending requests
//   starve_cnt   : consecutive data grants made while i_req was waiting
//   gnt_i, gnt_d : one-hot (or zero) grant decision, only acted on in IDLE
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic                i_req,
    input  logic                d_req,
    input  logic [STARVE_W-1:0] starve_cnt,
    output logic                gnt_i,
    output logic                gnt_d
);

    logic starved;

    assign starved = i_req && (starve_cnt == STARVE_W'(STARVE_LIM));
    assign gnt_d   = d_req && !starved;
    assign gnt_i   = i_req && !gnt_d;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single shared memory port between an instruction-fetch port and a
// MEM-stage load/store port. One access in flight at a time; the access is launched with
// a one-cycle m_en strobe and completed MEM_LAT cycles later with a one-cycle ack.
//   clk, reset                 : clock, synchronous active-high reset
//   i_req/i_addr               : fetch request (held until i_ack)
//   i_rdata/i_ack              : fetch data and completion pulse
//   d_req/d_we/d_addr/d_wdata  : load/store request (held until d_ack)
//   d_rdata/d_ack              : load data and completion pulse
//   m_en/m_we/m_addr/m_wdata   : memory access strobe and held command
//   m_rdata                    : memory read data, valid MEM_LAT cycles after m_en
//   stall_if/stall_mem         : pipeline stalls while a request is outstanding
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = MEM_LAT_DEF,
    parameter int unsigned STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    arb_state_t          state, state_next;
    logic [LAT_W-1:0]    lat_cnt, lat_next;
    logic [STARVE_W-1:0] starve_cnt, starve_next;
    logic                m_en_next, m_we_next, i_ack_next, d_ack_next;
    logic [ADDR_W-1:0]   m_addr_next;
    logic [DATA_W-1:0]   m_wdata_next, i_rdata_next, d_rdata_next;
    logic                gnt_i, gnt_d;

    arb_pick #(
        .STARVE_LIM(STARVE_LIM)
    ) u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .starve_cnt (starve_cnt),
        .gnt_i      (gnt_i),
        .gnt_d      (gnt_d)
    );

    assign stall_if  = i_req & ~i_ack;
    assign stall_mem = d_req & ~d_ack;

    always_comb begin
        state_next   = state;
        lat_next     = lat_cnt;
        starve_next  = starve_cnt;
        m_en_next    = 1'b0;
        m_we_next    = m_we;
        m_addr_next  = m_addr;
        m_wdata_next = m_wdata;
        i_ack_next   = 1'b0;
        d_ack_next   = 1'b0;
        i_rdata_next = i_rdata;
        d_rdata_next = d_rdata;

        unique case (state)
            IDLE: begin
                if (gnt_d) begin
                    state_next   = BUSY_D;
                    m_en_next    = 1'b1;
                    m_we_next    = d_we;
                    m_addr_next  = d_addr;
                    m_wdata_next = d_wdata;
                    lat_next     = LAT_W'(MEM_LAT);
                    // Count only data grants that made a waiting fetch lose.
                    if (!i_req) begin
                        starve_next = '0;
                    end else if (starve_cnt != STARVE_W'(STARVE_LIM)) begin
                        starve_next = starve_cnt + STARVE_W'(1);
                    end
                end else if (gnt_i) begin
                    state_next  = BUSY_I;
                    m_en_next   = 1'b1;
                    m_we_next   = 1'b0;
                    m_addr_next = i_addr;
                    lat_next    = LAT_W'(MEM_LAT);
                    starve_next = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                lat_next = lat_cnt - LAT_W'(1);
                // Counter is about to reach 0: m_rdata is valid now, complete the access.
                if (lat_cnt == LAT_W'(1)) begin
                    state_next = IDLE;
                    if (state == BUSY_I) begin
                        i_ack_next   = 1'b1;
                        i_rdata_next = m_rdata;
                    end else begin
                        d_ack_next = 1'b1;
                        if (!m_we) begin
                            d_rdata_next = m_rdata;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            m_en       <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            state      <= state_next;
            lat_cnt    <= lat_next;
            starve_cnt <= starve_next;
            m_en       <= m_en_next;
            m_we       <= m_we_next;
            m_addr     <= m_addr_next;
            m_wdata    <= m_wdata_next;
            i_ack      <= i_ack_next;
            d_ack      <= d_ack_next;
            i_rdata    <= i_rdata_next;
            d_rdata    <= d_rdata_next;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with MEM_LAT=1 and one with MEM_LAT=3,
// sharing clock, reset and request inputs, each with its own memory read model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [8:0]  i_addr, d_addr;
    logic [31:0] d_wdata;

    logic [31:0] i_rdata1, d_rdata1, m_wdata1, m_rdata1;
    logic [8:0]  m_addr1;
    logic        i_ack1, d_ack1, m_en1, m_we1, stall_if1, stall_mem1;

    logic [31:0] i_rdata3, d_rdata3, m_wdata3, m_rdata3;
    logic [8:0]  m_addr3;
    logic        i_ack3, d_ack3, m_en3, m_we3, stall_if3, stall_mem3;

    int n_checks = 0;
    int n_pass   = 0;
    int ov1      = 0;
    int ov3      = 0;

    always #5 clk = ~clk;

    // Memory contents keyed by the held m_addr.
    function automatic logic [31:0] mem_model(input logic [8:0] a);
        case (a)
            9'h010:  return 32'hDEADBEEF;
            9'h040:  return 32'hCAFEF00D;
            default: return 32'h5A000000 | 32'(a);
        endcase
    endfunction

    assign m_rdata1 = mem_model(m_addr1);
    assign m_rdata3 = mem_model(m_addr3);

    mem_arbiter #(
        .ADDR_W(9), .DATA_W(32), .MEM_LAT(1), .STARVE_LIM(4)
    ) u_dut1 (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata1), .i_ack(i_ack1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata1), .d_ack(d_ack1),
        .m_en(m_en1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1),
        .m_rdata(m_rdata1), .stall_if(stall_if1), .stall_mem(stall_mem1)
    );

    mem_arbiter #(
        .ADDR_W(9), .DATA_W(32), .MEM_LAT(3), .STARVE_LIM(4)
    ) u_dut3 (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata3), .i_ack(i_ack3),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata3), .d_ack(d_ack3),
        .m_en(m_en3), .m_we(m_we3), .m_addr(m_addr3), .m_wdata(m_wdata3),
        .m_rdata(m_rdata3), .stall_if(stall_if3), .stall_mem(stall_mem3)
    );

    always @(negedge clk) begin
        if (i_ack1 && d_ack1) ov1++;
        if (i_ack3 && d_ack3) ov3++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset   = 1'b1;
        i_req   = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        i_addr  = '0;
        d_addr  = '0;
        d_wdata = '0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    initial begin
        // Reset with a fetch already pending: nothing may be granted while reset is high.
        reset   = 1'b1;
        i_req   = 1'b1;
        i_addr  = 9'h010;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        tick;
        tick;
        check("rst_m_en1", m_en1, 0);
        check("rst_m_en3", m_en3, 0);
        check("rst_m_addr1", m_addr1, 0);
        check("rst_i_ack1", i_ack1, 0);
        check("rst_d_rdata1", d_rdata1, 0);
        check("rst_starve1", u_dut1.starve_cnt, 0);
        check("rst_stall_if1", stall_if1, 1);
        reset = 1'b0;

        // Single fetch, MEM_LAT=1.
        tick;
        check("f_m_en", m_en1, 1);
        check("f_m_addr", m_addr1, 9'h010);
        check("f_m_we", m_we1, 0);
        check("f_no_ack", i_ack1, 0);
        check("f_stall", stall_if1, 1);
        tick;
        check("f_ack", i_ack1, 1);
        check("f_rdata", i_rdata1, 32'hDEADBEEF);
        check("f_m_en_off", m_en1, 0);
        check("f_stall_ack", stall_if1, 0);
        i_req = 1'b0;
        tick;
        check("f_ack_off", i_ack1, 0);
        check("f_rdata_hold", i_rdata1, 32'hDEADBEEF);
        check("f_stall_after", stall_if1, 0);

        // Simultaneous fetch and load: data first, fetch right after d_ack.
        do_reset;
        i_req  = 1'b1;
        i_addr = 9'h010;
        d_req  = 1'b1;
        d_addr = 9'h040;
        tick;
        check("sim_d_grant", m_addr1, 9'h040);
        check("sim_m_en1", m_en1, 1);
        check("sim_stall_mem", stall_mem1, 1);
        check("sim_starve1", u_dut1.starve_cnt, 1);
        tick;
        check("sim_d_ack", d_ack1, 1);
        check("sim_d_rdata", d_rdata1, 32'hCAFEF00D);
        check("sim_i_no_ack", i_ack1, 0);
        d_req = 1'b0;
        tick;
        check("sim_i_grant", m_addr1, 9'h010);
        check("sim_m_en2", m_en1, 1);
        check("sim_d_ack_off", d_ack1, 0);
        check("sim_starve0", u_dut1.starve_cnt, 0);
        tick;
        check("sim_i_ack", i_ack1, 1);
        check("sim_i_rdata", i_rdata1, 32'hDEADBEEF);
        i_req = 1'b0;
        tick;

        // Starvation: continuous loads with a waiting fetch, STARVE_LIM=4.
        do_reset;
        i_req  = 1'b1;
        i_addr = 9'h010;
        d_req  = 1'b1;
        d_addr = 9'h0C0;
        for (int k = 1; k <= 4; k++) begin
            tick;
            check($sformatf("stv_d_grant%0d", k), m_addr1, 9'h0C0);
            check($sformatf("stv_m_en%0d", k), m_en1, 1);
            check($sformatf("stv_cnt%0d", k), u_dut1.starve_cnt, k);
            tick;
            check($sformatf("stv_d_ack%0d", k), d_ack1, 1);
            check($sformatf("stv_d_rdata%0d", k), d_rdata1, 32'h5A0000C0);
        end
        tick;
        check("stv_i_grant", m_addr1, 9'h010);
        check("stv_i_m_en", m_en1, 1);
        check("stv_cnt_clr", u_dut1.starve_cnt, 0);
        tick;
        check("stv_i_ack", i_ack1, 1);
        check("stv_d_no_ack", d_ack1, 0);
        i_req = 1'b0;
        d_req = 1'b0;
        tick;

        // Load then store, MEM_LAT=3: store leaves d_rdata untouched.
        do_reset;
        d_req  = 1'b1;
        d_addr = 9'h040;
        tick;
        check("ld3_m_en", m_en3, 1);
        tick;
        check("ld3_no_ack1", d_ack3, 0);
        tick;
        check("ld3_no_ack2", d_ack3, 0);
        tick;
        check("ld3_ack", d_ack3, 1);
        check("ld3_rdata", d_rdata3, 32'hCAFEF00D);
        d_we    = 1'b1;
        d_addr  = 9'h080;
        d_wdata = 32'h12345678;
        tick;
        check("st3_m_en", m_en3, 1);
        check("st3_m_we", m_we3, 1);
        check("st3_m_addr", m_addr3, 9'h080);
        check("st3_m_wdata", m_wdata3, 32'h12345678);
        for (int j = 1; j <= 2; j++) begin
            tick;
            check($sformatf("st3_m_en_off%0d", j), m_en3, 0);
            check($sformatf("st3_m_we_hold%0d", j), m_we3, 1);
            check($sformatf("st3_addr_hold%0d", j), m_addr3, 9'h080);
            check($sformatf("st3_wdata_hold%0d", j), m_wdata3, 32'h12345678);
            check($sformatf("st3_no_ack%0d", j), d_ack3, 0);
        end
        tick;
        check("st3_ack", d_ack3, 1);
        check("st3_rdata_kept", d_rdata3, 32'hCAFEF00D);
        d_req = 1'b0;
        d_we  = 1'b0;
        tick;
        check("st3_ack_off", d_ack3, 0);

        // Reset one cycle after a grant aborts the access; a fresh request then completes.
        do_reset;
        i_req  = 1'b1;
        i_addr = 9'h010;
        tick;
        check("ab_grant", m_en3, 1);
        reset = 1'b1;
        tick;
        check("ab_m_en", m_en3, 0);
        check("ab_m_addr", m_addr3, 0);
        check("ab_m_we", m_we3, 0);
        check("ab_i_ack", i_ack3, 0);
        check("ab_i_rdata", i_rdata3, 0);
        check("ab_lat", u_dut3.lat_cnt, 0);
        reset = 1'b0;
        tick;
        check("ab_regrant", m_en3, 1);
        check("ab_regrant_addr", m_addr3, 9'h010);
        check("ab_no_ack0", i_ack3, 0);
        tick;
        check("ab_no_ack1", i_ack3, 0);
        tick;
        check("ab_no_ack2", i_ack3, 0);
        tick;
        check("ab_ack", i_ack3, 1);
        check("ab_rdata", i_rdata3, 32'hDEADBEEF);
        i_req = 1'b0;
        tick;

        check("ack_overlap1", ov1, 0);
        check("ack_overlap3", ov3, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
